// File: rtl/cv32e40s_rf_scoreboard_pkg.sv
// Shared types for the register-file write scoreboard: per-entry state encoding
// and a small helper used wherever "live" has to be decided.
package cv32e40s_rf_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ISSUED    = 2'd1,
    SB_COMMITTED = 2'd2
  } sb_state_e;

  function automatic logic sb_is_live(sb_state_e s);
    return (s == SB_ISSUED) || (s == SB_COMMITTED);
  endfunction

endpackage

// File: rtl/cv32e40s_rf_scoreboard_entry.sv
// One scoreboard slot: FREE/ISSUED/COMMITTED state plus the id and rd it tracks,
// with live-qualified id and register compares for the top-level OR trees.
module cv32e40s_rf_scoreboard_entry
  import cv32e40s_rf_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_i,
  input  logic [ID_WIDTH-1:0]             issue_id_i,
  input  logic [ADDR_WIDTH-1:0]           issue_rd_i,
  input  logic                            commit_i,
  input  logic                            kill_i,
  input  logic                            result_i,
  input  logic [ID_WIDTH-1:0]             commit_id_i,
  input  logic [ID_WIDTH-1:0]             result_id_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] raddr_i,
  input  logic [ADDR_WIDTH-1:0]           rd_i,
  output logic                            live_o,
  output logic                            issued_o,
  output logic                            committed_o,
  output logic                            issue_id_match_o,
  output logic                            commit_id_match_o,
  output logic                            result_id_match_o,
  output logic [NUM_PORTS-1:0]            raddr_match_o,
  output logic                            rd_match_o
);

  typedef struct packed {
    sb_state_e             state;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] rd;
  } sb_entry_t;

  sb_entry_t entry_q, entry_d;

  // The top only asserts commit_i/result_i when the event is legal for this slot,
  // so the FSM here never has to second-guess the request.
  always_comb begin
    entry_d = entry_q;
    case (entry_q.state)
      SB_FREE: begin
        if (alloc_i) begin
          entry_d.state = SB_ISSUED;
          entry_d.id    = issue_id_i;
          entry_d.rd    = issue_rd_i;
        end
      end
      SB_ISSUED: begin
        if (commit_i) begin
          entry_d.state = (kill_i || result_i) ? SB_FREE : SB_COMMITTED;
        end
      end
      SB_COMMITTED: begin
        if (result_i) begin
          entry_d.state = SB_FREE;
        end
      end
      default: entry_d.state = SB_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign live_o            = sb_is_live(entry_q.state);
  assign issued_o          = (entry_q.state == SB_ISSUED);
  assign committed_o       = (entry_q.state == SB_COMMITTED);
  assign issue_id_match_o  = live_o && (entry_q.id == issue_id_i);
  assign commit_id_match_o = live_o && (entry_q.id == commit_id_i);
  assign result_id_match_o = live_o && (entry_q.id == result_id_i);
  assign rd_match_o        = live_o && (entry_q.rd == rd_i);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign raddr_match_o[p] = live_o && (entry_q.rd == raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
  end

endmodule

// File: rtl/cv32e40s_rf_scoreboard.sv
// Tracks in-flight register writes by id and raises RAW/WAW stalls for the ID stage.
// Define CV32E40S_SCOREBOARD_FWD_EN to let a same-cycle result hide its entry from the stalls.
module cv32e40s_rf_scoreboard
  import cv32e40s_rf_scoreboard_pkg::*;
#(
  parameter int unsigned REGFILE_NUM_READ_PORTS = 2,
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned ID_WIDTH               = 4,
  parameter int unsigned ADDR_WIDTH             = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         issue_valid_i,
  output logic                                         issue_ready_o,
  input  logic [ID_WIDTH-1:0]                          issue_id_i,
  input  logic [ADDR_WIDTH-1:0]                        issue_rd_i,
  input  logic                                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]                          commit_id_i,
  input  logic                                         commit_kill_i,
  input  logic                                         result_valid_i,
  input  logic [ID_WIDTH-1:0]                          result_id_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0]            rf_re_id_i,
  input  logic [REGFILE_NUM_READ_PORTS*ADDR_WIDTH-1:0] rf_raddr_id_i,
  input  logic                                         rf_we_id_i,
  input  logic [ADDR_WIDTH-1:0]                        rd_id_i,
  output logic [REGFILE_NUM_READ_PORTS-1:0]            stall_raw_o,
  output logic                                         stall_waw_o,
  output logic [$clog2(DEPTH+1)-1:0]                   count_o,
  output logic                                         busy_o,
  output logic                                         proto_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] live, issued, committed;
  logic [DEPTH-1:0] issue_hit, commit_hit, result_hit, waw_hit;
  logic [DEPTH-1:0] alloc_oh, alloc_sel, commit_en, result_en, free_en, hazard_en;
  logic [REGFILE_NUM_READ_PORTS-1:0] raw_hit [DEPTH];

  logic             issue_dup, issue_err, alloc, commit_err, result_err, alloc_found;
  logic [CNT_W-1:0] count_q, count_d, free_cnt;
  logic             proto_err_q, proto_err_d;

  assign issue_ready_o = (count_q < CNT_W'(DEPTH));

  assign issue_dup = |issue_hit;
  assign issue_err = issue_valid_i && (!issue_ready_o || issue_dup);
  assign alloc     = issue_valid_i && issue_ready_o && !issue_dup && (issue_rd_i != '0);

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (!live[e] && !alloc_found) begin
        alloc_oh[e] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign alloc_sel = {DEPTH{alloc}} & alloc_oh;

  assign commit_en  = {DEPTH{commit_valid_i}} & commit_hit;
  assign commit_err = commit_valid_i && !(|commit_hit);

  // A result is legal on a COMMITTED entry, or on an ISSUED one committed (not killed) this cycle.
  assign result_en  = {DEPTH{result_valid_i}} & result_hit &
                      (committed | (issued & commit_en & {DEPTH{!commit_kill_i}}));
  assign result_err = result_valid_i && !(|result_en);

  assign free_en = (issued & commit_en & ({DEPTH{commit_kill_i}} | result_en)) |
                   (committed & result_en);

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    cv32e40s_rf_scoreboard_entry #(
      .NUM_PORTS  (REGFILE_NUM_READ_PORTS),
      .ID_WIDTH   (ID_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_entry (
      .clk               (clk),
      .rst               (rst),
      .alloc_i           (alloc_sel[e]),
      .issue_id_i        (issue_id_i),
      .issue_rd_i        (issue_rd_i),
      .commit_i          (commit_en[e]),
      .kill_i            (commit_kill_i),
      .result_i          (result_en[e]),
      .commit_id_i       (commit_id_i),
      .result_id_i       (result_id_i),
      .raddr_i           (rf_raddr_id_i),
      .rd_i              (rd_id_i),
      .live_o            (live[e]),
      .issued_o          (issued[e]),
      .committed_o       (committed[e]),
      .issue_id_match_o  (issue_hit[e]),
      .commit_id_match_o (commit_hit[e]),
      .result_id_match_o (result_hit[e]),
      .raddr_match_o     (raw_hit[e]),
      .rd_match_o        (waw_hit[e])
    );
  end

  always_comb begin
    free_cnt = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      free_cnt = free_cnt + CNT_W'(free_en[e]);
    end
  end

  // Alloc only happens below DEPTH and frees only hit live entries, so this cannot wrap.
  assign count_d     = count_q + CNT_W'(alloc) - free_cnt;
  assign proto_err_d = proto_err_q || issue_err || commit_err || result_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef CV32E40S_SCOREBOARD_FWD_EN
  assign hazard_en = ~(committed & result_hit & {DEPTH{result_valid_i}});
`else
  assign hazard_en = '1;
`endif

  always_comb begin
    stall_raw_o = '0;
    for (int unsigned p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        stall_raw_o[p] = stall_raw_o[p] | (raw_hit[e][p] & hazard_en[e]);
      end
      stall_raw_o[p] = stall_raw_o[p] & rf_re_id_i[p] &
                       (rf_raddr_id_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    end
  end

  assign stall_waw_o = rf_we_id_i && (rd_id_i != '0) && (|(waw_hit & hazard_en));

  assign count_o     = count_q;
  assign busy_o      = (count_q != '0);
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_cv32e40s_rf_scoreboard.sv
// Directed and random stimulus against a queue-based model of live register writes.
module tb_cv32e40s_rf_scoreboard;

  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid_i, issue_ready_o;
  logic [IDW-1:0]    issue_id_i;
  logic [AW-1:0]     issue_rd_i;
  logic              commit_valid_i, commit_kill_i;
  logic [IDW-1:0]    commit_id_i;
  logic              result_valid_i;
  logic [IDW-1:0]    result_id_i;
  logic [NP-1:0]     rf_re_id_i;
  logic [NP*AW-1:0]  rf_raddr_id_i;
  logic              rf_we_id_i;
  logic [AW-1:0]     rd_id_i;
  logic [NP-1:0]     stall_raw_o;
  logic              stall_waw_o;
  logic [CW-1:0]     count_o;
  logic              busy_o, proto_err_o;

  cv32e40s_rf_scoreboard #(
    .REGFILE_NUM_READ_PORTS (NP),
    .DEPTH                  (DEPTH),
    .ID_WIDTH               (IDW),
    .ADDR_WIDTH             (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .result_valid_i (result_valid_i),
    .result_id_i    (result_id_i),
    .rf_re_id_i     (rf_re_id_i),
    .rf_raddr_id_i  (rf_raddr_id_i),
    .rf_we_id_i     (rf_we_id_i),
    .rd_id_i        (rd_id_i),
    .stall_raw_o    (stall_raw_o),
    .stall_waw_o    (stall_waw_o),
    .count_o        (count_o),
    .busy_o         (busy_o),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int rd;
    bit com;
  } ent_t;

  ent_t m[$];
  bit   m_err;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input int id);
    foreach (m[k]) if (m[k].id == id) return k;
    return -1;
  endfunction

  task automatic idle();
    issue_valid_i  = 0; issue_id_i  = '0; issue_rd_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
    result_valid_i = 0; result_id_i = '0;
    rf_re_id_i = '0; rf_raddr_id_i = '0; rf_we_id_i = 0; rd_id_i = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [NP-1:0] er;
    logic          ew;
    int            ra;
    er = '0;
    ew = 1'b0;
    foreach (m[k]) begin
      bit masked;
      masked = 0;
`ifdef CV32E40S_SCOREBOARD_FWD_EN
      masked = m[k].com && result_valid_i && (m[k].id == int'(result_id_i));
`endif
      if (!masked) begin
        for (int p = 0; p < NP; p++) begin
          ra = int'(rf_raddr_id_i[p*AW +: AW]);
          if (rf_re_id_i[p] && ra != 0 && m[k].rd == ra) er[p] = 1'b1;
        end
        if (rf_we_id_i && rd_id_i != 0 && m[k].rd == int'(rd_id_i)) ew = 1'b1;
      end
    end
    chk($sformatf("%s.raw", tag),   32'(stall_raw_o),   32'(er));
    chk($sformatf("%s.waw", tag),   32'(stall_waw_o),   32'(ew));
    chk($sformatf("%s.count", tag), 32'(count_o),       32'(m.size()));
    chk($sformatf("%s.busy", tag),  32'(busy_o),        32'(m.size() != 0));
    chk($sformatf("%s.ready", tag), 32'(issue_ready_o), 32'(m.size() < DEPTH));
    chk($sformatf("%s.perr", tag),  32'(proto_err_o),   32'(m_err));
  endtask

  // Next live set from this cycle's events, all judged against the current live set.
  task automatic model_step();
    ent_t nq[$];
    ent_t e;
    bit   ready, gone;
    int   kc, kr;
    ready = (m.size() < DEPTH);
    kc = commit_valid_i ? find(int'(commit_id_i)) : -1;
    kr = result_valid_i ? find(int'(result_id_i)) : -1;
    if (commit_valid_i && kc < 0) m_err = 1;
    if (result_valid_i) begin
      if (kr < 0) m_err = 1;
      else if (!m[kr].com && !(kc == kr && !commit_kill_i)) m_err = 1;
    end
    foreach (m[k]) begin
      e = m[k];
      gone = 0;
      if (k == kr && (m[k].com || (kc == k && !commit_kill_i))) gone = 1;
      if (k == kc && !m[k].com) begin
        if (commit_kill_i) gone = 1;
        else e.com = 1;
      end
      if (!gone) nq.push_back(e);
    end
    if (issue_valid_i) begin
      if (!ready || find(int'(issue_id_i)) >= 0) m_err = 1;
      else if (issue_rd_i != 0) nq.push_back('{int'(issue_id_i), int'(issue_rd_i), 1'b0});
    end
    m = nq;
  endtask

  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1;
    #1;
    m.delete();
    m_err = 0;
    check_outputs(tag);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic issue(input int id, input int rd);
    issue_valid_i = 1; issue_id_i = IDW'(id); issue_rd_i = AW'(rd);
  endtask

  initial begin
    int k;
    int cand[$];
    rst = 1;
    idle();
    m_err = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    cycle("reset");

    // RAW on port 1, clearing through commit and result
    issue(3, 5); cycle("t1.issue");
    idle(); rf_re_id_i = 2'b10; rf_raddr_id_i = {5'd5, 5'd0};
    #1 chk("t1.raw_port1", 32'(stall_raw_o), 32'h2);
    cycle("t1.read");
    commit_valid_i = 1; commit_id_i = 4'd3; cycle("t1.commit");
    commit_valid_i = 0; result_valid_i = 1; result_id_i = 4'd3; cycle("t1.result");
    result_valid_i = 0;
    #1 chk("t1.raw_clear", 32'(stall_raw_o), 32'h0);
    chk("t1.count0", 32'(count_o), 32'h0);
    cycle("t1.after");

    // Fill, free one via result, then issue the fifth
    do_reset("t2.rst");
    for (int i = 0; i < DEPTH; i++) begin issue(i, i + 1); cycle("t2.fill"); end
    idle();
    #1 chk("t2.full_ready", 32'(issue_ready_o), 32'h0);
    chk("t2.full_count", 32'(count_o), 32'h4);
    commit_valid_i = 1; commit_id_i = 4'd0; cycle("t2.commit");
    idle(); result_valid_i = 1; result_id_i = 4'd0;
    #1 chk("t2.hold_ready", 32'(issue_ready_o), 32'h0);
    cycle("t2.result");
    idle();
    #1 chk("t2.ready_again", 32'(issue_ready_o), 32'h1);
    issue(4, 6); cycle("t2.fifth");
    idle();
    #1 chk("t2.count_after", 32'(count_o), 32'h4);
    cycle("t2.idle");

    // Kill frees the entry; WAW gone the cycle after
    do_reset("t3.rst");
    issue(1, 7); cycle("t3.issue");
    idle(); commit_valid_i = 1; commit_id_i = 4'd1; commit_kill_i = 1;
    rf_we_id_i = 1; rd_id_i = 5'd7;
    #1 chk("t3.waw_before", 32'(stall_waw_o), 32'h1);
    cycle("t3.kill");
    commit_valid_i = 0; commit_kill_i = 0;
    #1 chk("t3.waw_after", 32'(stall_waw_o), 32'h0);
    cycle("t3.after");

    // rd = x0 is accepted but never tracked
    idle(); issue(2, 0); cycle("t4.issue_x0");
    idle(); rf_re_id_i = 2'b11; rf_we_id_i = 1;
    #1 chk("t4.count", 32'(count_o), 32'h0);
    chk("t4.raw", 32'(stall_raw_o), 32'h0);
    cycle("t4.read");

    // Alloc, kill and result on three entries in one cycle
    do_reset("t5.rst");
    issue(0, 1); cycle("t5.a");
    issue(1, 2); cycle("t5.b");
    issue(2, 3); cycle("t5.c");
    idle(); commit_valid_i = 1; commit_id_i = 4'd1; cycle("t5.commit");
    idle(); issue(5, 4); commit_valid_i = 1; commit_id_i = 4'd0; commit_kill_i = 1;
    result_valid_i = 1; result_id_i = 4'd1; cycle("t5.mix");
    idle();
    #1 chk("t5.count", 32'(count_o), 32'h2);
    cycle("t5.after");

    // Stray result sets a sticky error
    idle(); result_valid_i = 1; result_id_i = 4'd9; cycle("t6.stray");
    idle();
    repeat (3) cycle("t6.idle");
    #1 chk("t6.sticky", 32'(proto_err_o), 32'h1);
    cycle("t6.end");

    // Asynchronous reset with live entries and active reads
    do_reset("t7.pre");
    issue(1, 3); cycle("t7.a");
    issue(2, 4); cycle("t7.b");
    issue(3, 5); cycle("t7.c");
    idle(); rf_re_id_i = 2'b11; rf_raddr_id_i = {5'd4, 5'd3}; rf_we_id_i = 1; rd_id_i = 5'd5;
    do_reset("t7.rst");
    chk("t7.count", 32'(count_o), 32'h0);
    chk("t7.busy", 32'(busy_o), 32'h0);
    chk("t7.raw", 32'(stall_raw_o), 32'h0);
    chk("t7.ready", 32'(issue_ready_o), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      rf_re_id_i    = NP'($urandom_range(0, 3));
      rf_raddr_id_i = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      rf_we_id_i    = $urandom_range(0, 1);
      rd_id_i       = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0 && (m.size() < DEPTH || $urandom_range(0, 19) == 0)) begin
        k = $urandom_range(0, 15);
        if ($urandom_range(0, 29) != 0)
          for (int t = 0; t < 16 && find(k) >= 0; t++) k = (k + 1) % 16;
        issue(k, $urandom_range(0, 7));
      end
      cand.delete();
      foreach (m[j]) if (!m[j].com) cand.push_back(j);
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = cand[$urandom_range(0, cand.size() - 1)];
        commit_valid_i = 1; commit_id_i = IDW'(m[k].id);
        commit_kill_i  = ($urandom_range(0, 3) == 0);
      end
      cand.delete();
      foreach (m[j]) begin
        if (m[j].com) cand.push_back(j);
        else if (commit_valid_i && !commit_kill_i && int'(commit_id_i) == m[j].id) cand.push_back(j);
      end
      if (cand.size() > 0 && $urandom_range(0, 1) == 0) begin
        k = cand[$urandom_range(0, cand.size() - 1)];
        result_valid_i = 1; result_id_i = IDW'(m[k].id);
      end else if ($urandom_range(0, 79) == 0) begin
        result_valid_i = 1; result_id_i = IDW'($urandom_range(0, 15));
        if (commit_valid_i && commit_kill_i && result_id_i == commit_id_i) result_valid_i = 0;
      end
      cycle("rand");
      if (i % 100 == 99) do_reset("rand.rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
